// File: rtl/alu_result_pipe_mux.sv
// rtl/alu_result_pipe_mux.sv - registered ALU result selector with valid/ready and multi-cycle wait
module alu_result_pipe_mux #(
  parameter int                 WIDTH   = 32,
  parameter int                 NUM_SRC = 20,
  parameter int                 SEL_W   = 5,
  parameter logic [NUM_SRC-1:0] MC_MASK = '0,
  parameter int                 TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic             in_hit;
  logic             in_mc;
  logic [WIDTH-1:0] in_src;
  logic             wait_done;
  logic [WIDTH-1:0] wait_src;

  // in_ready must not see src_data/src_done: only state, out_ready and reset
  assign in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_FULL) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;

  // Source lookup by loop so out-of-range selects never index past the bus
  always_comb begin
    in_hit    = 1'b0;
    in_mc     = 1'b0;
    in_src    = '0;
    wait_done = 1'b0;
    wait_src  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_sel == SEL_W'(i)) begin
        in_hit = 1'b1;
        in_mc  = MC_MASK[i];
        in_src = src_data[i*WIDTH +: WIDTH];
      end
      if (sel_q == SEL_W'(i)) begin
        wait_done = src_done[i];
        wait_src  = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: accept handling shared by IDLE and FULL (back-to-back), WAIT runs the watchdog
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    out_err_d  = out_err_q;
    case (state_q)
      S_IDLE, S_FULL: begin
        if (accept) begin
          if (!in_hit) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
            out_sel_d  = in_sel;
            state_d    = S_FULL;
          end else if (in_mc) begin
            // done in the accept cycle belongs to no op yet, so it is not looked at
            sel_d   = in_sel;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            out_data_d = in_src;
            out_err_d  = 1'b0;
            out_sel_d  = in_sel;
            state_d    = S_FULL;
          end
        end else if (state_q == S_FULL && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (wait_done) begin
          out_data_d = wait_src;
          out_err_d  = 1'b0;
          out_sel_d  = sel_q;
          state_d    = S_FULL;
        end else if (cnt_q >= CNT_LAST) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          out_sel_d  = sel_q;
          state_d    = S_FULL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule

// File: doc/alu_result_pipe_mux.md
# alu_result_pipe_mux

Parametrised, registered ALU result selector with a valid/ready handshake. It replaces the flat combinational result mux at the ALU output. Single-cycle sources pass through with one cycle of latency. For multi-cycle sources (mul/div/shift-iterative) it waits for the unit's done pulse. A watchdog covers hung units.

## Interface
Parameters:
- `WIDTH`, default 32: result width.
- `NUM_SRC`, default 20: number of result sources.
- `SEL_W`, default 5: select width; must satisfy 2^SEL_W >= NUM_SRC.
- `MC_MASK`, default 20'h0: bit i = 1 marks source i as multi-cycle.
- `TIMEOUT`, default 64: maximum wait cycles for a multi-cycle source (>= 2).

Ports:
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: op select presented.
- `in_ready`, out, 1: block accepts the op this cycle.
- `in_sel`, in, SEL_W: source index.
- `src_data`, in, NUM_SRC*WIDTH: flattened source results; source i is `[i*WIDTH +: WIDTH]`.
- `src_done`, in, NUM_SRC: one-cycle done pulse per multi-cycle source. Bits of single-cycle sources are ignored.
- `out_valid`, out, 1: result register holds a result.
- `out_ready`, in, 1: consumer takes the result.
- `out_data`, out, WIDTH: registered result.
- `out_sel`, out, SEL_W: source index of `out_data`.
- `out_err`, out, 1: result is an error (bad select or timeout); `out_data` is 0.

## Operation
- **States:** IDLE, WAIT, FULL.
- **Accept rule:** `in_ready = rst_n && (state==IDLE || (state==FULL && out_ready))`. An op is accepted on an edge where `in_valid && in_ready`.
- **On accept, with `in_sel >= NUM_SRC`:** load `out_data`=0, `out_err`=1, `out_sel`=`in_sel`. Go to FULL.
- **On accept, single-cycle source:** load `out_data`=src_data[in_sel], `out_err`=0, `out_sel`=`in_sel`. Go to FULL.
- **On accept, multi-cycle source:** latch `sel_q`=`in_sel`, clear the wait counter, go to WAIT. `src_done` in the accept cycle is ignored.
- **WAIT:**
  - The counter increments each cycle.
  - If `src_done[sel_q]`=1: load `out_data`=src_data[sel_q], `out_err`=0, then go to FULL.
  - Otherwise, if the counter has reached TIMEOUT-1: load `out_data`=0, `out_err`=1, then go to FULL.
  - Done has priority over timeout in the same cycle.
  - `src_done` bits for other sources are ignored.
- **FULL:**
  - `out_valid`=1.
  - If `out_ready` and no accept: go to IDLE.
  - If `out_ready` with a simultaneous accept: apply the accept rules above (back-to-back).
  - If not `out_ready`: `out_data`, `out_sel` and `out_err` hold stable.
- **Width/arithmetic:** the counter is $clog2(TIMEOUT) bits and saturates; it never wraps. No truncation of `out_data`.
- **Reset mid-operation:** any in-flight WAIT or FULL result is discarded. A later `src_done` for the discarded op is ignored because the block is in IDLE.

## Timing
- **Reset values while `rst_n`=0 at an edge:** state IDLE, `out_valid`=0, `out_data`=0, `out_sel`=0, `out_err`=0, counter 0. `in_ready` is 0 combinationally while `rst_n`=0.
- **Single-cycle latency:** accept at edge k gives `out_valid`=1 after edge k.
- **Throughput:** 1 op/cycle with `out_ready` held high.
- **Multi-cycle latency:** done sampled at edge m gives `out_valid`=1 after edge m.
- **Timeout:** accept at edge k with no done gives the error result valid after edge k+TIMEOUT.
- **Input sampling:** `src_data` is sampled only on the loading edge; later changes do not affect `out_data`.
- **No combinational paths:** none from `src_data`/`src_done` to any output. `in_ready` depends combinationally only on state, `out_ready` and `rst_n`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, `out_valid`=0, `out_data`=0.
- **Back-to-back single-cycle:** `out_ready`=1, sels 0,1,2 on consecutive cycles with src i = 32'h100+i -> `out_data` 32'h100, 32'h101, 32'h102 on consecutive cycles; `in_ready` stays 1.
- **Multi-cycle:** MC_MASK bit 17 set, sel 17, `src_done[17]` pulsed 5 cycles after accept with data 32'hDEAD_BEEF -> `out_valid` one cycle after the pulse, `out_data`=32'hDEADBEEF, `in_ready`=0 throughout WAIT. A stray `src_done[18]` during WAIT is ignored.
- **Timeout:** sel 17 with no done, TIMEOUT=64 -> after 64 cycles `out_valid`=1, `out_err`=1, `out_data`=0. Repeat with done exactly at the timeout cycle -> `out_err`=0.
- **Backpressure and bad select:** `in_sel`=25 with NUM_SRC=20 -> `out_err`=1, `out_sel`=25. Hold `out_ready`=0 for 4 cycles -> outputs stable and `in_ready`=0, then `out_ready`=1 -> `in_ready`=1 that cycle.
- **Reset in WAIT:** assert `rst_n`=0 during WAIT, then `src_done` arrives -> `out_valid` stays 0.
